xmem_master: RTL

//  Initiator side of the AVR multiplexed external-memory (XMEM) bus. Converts a

---
 rtl/xmem_master_pkg.sv | 40 ++++
 rtl/xmem_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/xmem_master_pkg.sv
// Shared definitions for the XMEM bus initiator: FSM state encoding, phase
// counter sizing and the FPGA IO register map, so the IO decoder and benches
// can use the same names.
package xmem_master_pkg;

    // Bus-cycle phases, in the order a transaction walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } xmem_state_e;

    // One down-counter serves every multi-cycle phase. Eight bits allow up to
    // 256 cycles per phase, which covers any sensible ALE/hold setting.
    localparam int PHASE_W = 8;

    // IO register page as seen by the AVR (0x1100-0x11FF).
    localparam logic [7:0]  IO_PAGE      = 8'h11;
    localparam logic [15:0] MOTOR_BASE   = 16'h1100;
    localparam logic [15:0] ENC_BASE     = 16'h110C;
    localparam logic [15:0] DIN          = 16'h111E;
    localparam logic [15:0] SERVO_BASE   = 16'h1120;
    localparam logic [15:0] DIO_MODE     = 16'h1130;
    localparam logic [15:0] DIO_PWM_BASE = 16'h1131;
    localparam logic [15:0] VER_MAJ      = 16'h11FE;
    localparam logic [15:0] VER_MIN      = 16'h11FF;

    // Load value for the phase counter: a phase lasting N cycles counts N-1..0.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

    // True when an address falls inside the FPGA IO register page.
    function automatic logic is_io_addr(input logic [15:0] addr);
        return addr[15:8] == IO_PAGE;
    endfunction

endpackage

// File: rtl/xmem_master.sv
// AVR-style multiplexed external-memory bus initiator. A single-beat
// request/acknowledge port on the FPGA side is turned into one
// ALE -> address hold -> nRD/nWR strobe -> hold bus cycle. Every bus output
// comes straight from a flop so the strobes cannot glitch.
//
// Request handshake: req is looked at only while the FSM is idle. The cycle
// after the accepting edge shows ack=1 for exactly one cycle, and we/addr/wdata
// have been captured at that edge. busy is high from that cycle up to and
// including the cycle showing done=1; done is a one-cycle completion pulse.
// A request raised while busy is dropped, not queued. The earliest next
// accept is the edge ending the first idle cycle after done.
module xmem_master
    import xmem_master_pkg::*;
#(
    parameter int ALE_CYCLES  = 1,  // cycles ale is high with address driven (>=1)
    parameter int WAIT_STATES = 0,  // extra strobe cycles beyond the first (0..15)
    parameter int HOLD_CYCLES = 1   // cycles a/ad are held after strobe release (>=1)
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        ale,
    output logic        nRD,
    output logic        nWR,
    output logic [7:0]  a,
    inout  wire  [7:0]  ad,
    output logic [2:0]  dbg_state
);

    localparam logic [PHASE_W-1:0] ALE_LOAD  = phase_load(ALE_CYCLES);
    localparam logic [PHASE_W-1:0] STB_LOAD  = phase_load(WAIT_STATES + 1);
    localparam logic [PHASE_W-1:0] HOLD_LOAD = phase_load(HOLD_CYCLES);

    xmem_state_e        state_q;
    logic [PHASE_W-1:0] phase_q;
    logic               we_q;
    logic [7:0]         wdata_q;
    logic               ack_q;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         rdata_q;
    logic               ale_q;
    logic               nrd_q;
    logic               nwr_q;
    logic [7:0]         a_q;
    logic [7:0]         ad_out_q;
    logic               ad_oe_q;

    logic               phase_last;
    logic               done_d;

    // Phase bookkeeping: when the current phase ends, and whether the next
    // cycle is the final hold cycle (the one that carries the done pulse).
    always_comb begin
        phase_last = (phase_q == '0);
        done_d     = 1'b0;
        if (state_q == ST_STROBE && phase_last && HOLD_LOAD == '0) begin
            done_d = 1'b1;
        end else if (state_q == ST_HOLD && phase_q == PHASE_W'(1)) begin
            done_d = 1'b1;
        end
    end

    // Bus-cycle FSM with phase counter, request capture and registered bus outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 8'h00;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 8'h00;
            ale_q    <= 1'b0;
            nrd_q    <= 1'b1;
            nwr_q    <= 1'b1;
            a_q      <= 8'h00;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= done_d;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        ack_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        we_q     <= we;
                        wdata_q  <= wdata;
                        a_q      <= addr[15:8];
                        ad_out_q <= addr[7:0];
                        ad_oe_q  <= 1'b1;
                        ale_q    <= 1'b1;
                        phase_q  <= ALE_LOAD;
                        state_q  <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (phase_last) begin
                        // Address stays on a/ad for one more cycle after ale falls
                        // so the responder latches a stable value.
                        ale_q   <= 1'b0;
                        state_q <= ST_LATCH;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end

                ST_LATCH: begin
                    phase_q <= STB_LOAD;
                    state_q <= ST_STROBE;
                    if (we_q) begin
                        nwr_q    <= 1'b0;
                        ad_out_q <= wdata_q;
                        ad_oe_q  <= 1'b1;
                    end else begin
                        // Release ad on the same edge nRD falls: the responder
                        // owns the bus for the whole read strobe.
                        nrd_q   <= 1'b0;
                        ad_oe_q <= 1'b0;
                    end
                end

                ST_STROBE: begin
                    if (phase_last) begin
                        // nRD is still low at this edge, so ad carries read data.
                        if (!we_q) begin
                            rdata_q <= ad;
                        end
                        nrd_q   <= 1'b1;
                        nwr_q   <= 1'b1;
                        phase_q <= HOLD_LOAD;
                        state_q <= ST_HOLD;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (phase_last) begin
                        busy_q  <= 1'b0;
                        ad_oe_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    ale_q   <= 1'b0;
                    nrd_q   <= 1'b1;
                    nwr_q   <= 1'b1;
                    ad_oe_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ad        = ad_oe_q ? ad_out_q : 8'bzzzz_zzzz;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ale       = ale_q;
    assign nRD       = nrd_q;
    assign nWR       = nwr_q;
    assign a         = a_q;
    assign dbg_state = state_q;

endmodule
